aes_v2_issue: RTL and testbench

Issue/writeback sequencer sitting directly upstream of the aes_v2 functional unit (FU) in the core's execute stage. Accepts one decoded AES instruction (sub/mix, enc/dec, rs1, rs2, rd index) from decode. Registers the operands and holds them stable on the FU interface until the FU signals ready. Captures the FU result and presents it to register-file writeback with a valid/ready handshake, supporting stall, flush and a latency watchdog.

---
 rtl/aes_v2_pkg.sv | 18 +
 rtl/aes_v2_issue.sv | 153 +++++++++++++++
 tb/tb_aes_v2_issue.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_v2_pkg.sv
// Shared types for the aes_v2 issue/writeback sequencer.
// State encoding, width default and the op-field bundle.
package aes_v2_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic sub;
    logic enc;
  } aes_op_t;

endpackage

// File: rtl/aes_v2_issue.sv
// Issue/writeback sequencer in front of the aes_v2 FU.
// Holds operands stable for the FU, then hands the result to writeback.
module aes_v2_issue
  import aes_v2_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_sub,
  input  logic            req_enc,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            fu_valid,
  output logic            fu_sub,
  output logic            fu_enc,
  output logic [XLEN-1:0] fu_rs1,
  output logic [XLEN-1:0] fu_rs2,
  input  logic            fu_ready,
  input  logic [XLEN-1:0] fu_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_e          state_q;
  state_e          state_d;
  aes_op_t         op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] res_q;
  logic [RD_W-1:0] rd_q;
  logic            kill_q;
  logic            err_q;
  logic [CW-1:0]   wd_q;

  logic accept;
  logic discard;
  logic in_exec;
  logic wd_tick;

  assign in_exec = (state_q == ST_EXEC);

  assign req_ready = !flush && !g_reset &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_WB) && wb_ready));

  assign accept  = req_valid && req_ready;
  // A flush landing on the fu_ready cycle also kills the result.
  assign discard = kill_q || flush;
  assign wd_tick = in_exec && !fu_ready;

  assign fu_valid = in_exec;
  assign fu_sub   = op_q.sub;
  assign fu_enc   = op_q.enc;
  assign fu_rs1   = rs1_q;
  assign fu_rs2   = rs2_q;

  assign wb_valid = (state_q == ST_WB);
  assign wb_addr  = rd_q;
  assign wb_data  = res_q;

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

  // Next-state selection for the IDLE/EXEC/WB sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (fu_ready) state_d = discard ? ST_IDLE : ST_WB;
      end
      ST_WB: begin
        if (flush)         state_d = ST_IDLE;
        else if (wb_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge g_clk) begin
    if (g_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Operand and destination capture on accept only.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q.sub <= req_sub;
      op_q.enc <= req_enc;
      rs1_q    <= req_rs1;
      rs2_q    <= req_rs2;
      rd_q     <= req_rd;
    end
  end

  // Result capture when a live op completes.
  always_ff @(posedge g_clk) begin
    if (g_reset)
      res_q <= '0;
    else if (in_exec && fu_ready && !discard)
      res_q <= fu_rd;
  end

  // Kill flag: a flushed op keeps running, its result is dropped.
  always_ff @(posedge g_clk) begin
    if (g_reset)
      kill_q <= 1'b0;
    else if (in_exec && fu_ready)
      kill_q <= 1'b0;
    else if (in_exec && flush)
      kill_q <= 1'b1;
    else if (accept)
      kill_q <= 1'b0;
  end

  // Saturating watchdog with a sticky error flag.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        wd_q <= '0;
      else if (wd_tick && (wd_q != CW'(TIMEOUT)))
        wd_q <= wd_q + 1'b1;
      if (wd_tick && (wd_q >= WD_LAST))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_v2_issue.sv
// Directed bench for aes_v2_issue.
// The FU is modelled inline with hand-computed aes_v2 results.
module tb_aes_v2_issue;

  logic        g_clk;
  logic        g_reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_sub;
  logic        req_enc;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        fu_valid;
  logic        fu_sub;
  logic        fu_enc;
  logic [31:0] fu_rs1;
  logic [31:0] fu_rs2;
  logic        fu_ready;
  logic [31:0] fu_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        err;

  int tests;
  int fails;

  aes_v2_issue #(
    .XLEN(32),
    .RD_W(5),
    .TIMEOUT(16)
  ) dut (
    .g_clk(g_clk),
    .g_reset(g_reset),
    .flush(flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sub(req_sub),
    .req_enc(req_enc),
    .req_rs1(req_rs1),
    .req_rs2(req_rs2),
    .req_rd(req_rd),
    .fu_valid(fu_valid),
    .fu_sub(fu_sub),
    .fu_enc(fu_enc),
    .fu_rs1(fu_rs1),
    .fu_rs2(fu_rs2),
    .fu_ready(fu_ready),
    .fu_rd(fu_rd),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .busy(busy),
    .err(err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Offer one op in IDLE; it is accepted at the next edge.
  task automatic issue(input logic s, input logic e,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_valid = 1'b1;
    req_sub   = s;
    req_enc   = e;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_rs1   = 32'hFFFF_0000;
    req_rs2   = 32'h0000_FFFF;
    req_sub   = ~s;
    req_enc   = ~e;
    #1;
    chk("fu_valid", {31'd0, fu_valid}, 32'd1);
    chk("fu_op", {30'd0, fu_sub, fu_enc}, {30'd0, s, e});
    chk("fu_rs1", fu_rs1, a);
    chk("fu_rs2", fu_rs2, b);
  endtask

  // Extra EXEC cycles with no fu_ready; operands must not move.
  task automatic exec_wait(input int n, input logic [31:0] a,
                           input logic [31:0] b);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_valid", {31'd0, fu_valid}, 32'd1);
      chk("hold_rs1", fu_rs1, a);
      chk("hold_rs2", fu_rs2, b);
      chk("hold_nowb", {31'd0, wb_valid}, 32'd0);
    end
  endtask

  task automatic fu_done(input logic [31:0] res);
    fu_ready = 1'b1;
    fu_rd    = res;
    tick();
    fu_ready = 1'b0;
    fu_rd    = 32'hBAD0_BAD0;
    #1;
  endtask

  task automatic wb_check(input logic [4:0] rd,
                          input logic [31:0] res);
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
    chk("wb_data", wb_data, res);
    chk("wb_fu_off", {31'd0, fu_valid}, 32'd0);
  endtask

  task automatic wb_take();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    #1;
    chk("wb_done", {30'd0, wb_valid, busy}, 32'd0);
  endtask

  task automatic full_op(input logic s, input logic e,
                         input logic [31:0] a,
                         input logic [4:0] rd,
                         input logic [31:0] res,
                         input int dly);
    issue(s, e, a, a, rd);
    exec_wait(dly, a, a);
    fu_done(res);
    wb_check(rd, res);
    wb_take();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    g_reset   = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_sub   = 1'b0;
    req_enc   = 1'b0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_rd    = '0;
    fu_ready  = 1'b0;
    fu_rd     = '0;
    wb_ready  = 1'b0;
    tick();
    tick();
    chk("rst_ctl", {27'd0, fu_valid, wb_valid, busy, err, req_ready},
        32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_wbaddr", {27'd0, wb_addr}, 32'd0);
    chk("rst_rs1", fu_rs1, 32'd0);
    g_reset = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);

    // SubBytes fwd of zero, with a 2-cycle FU
    full_op(1'b1, 1'b1, 32'h0000_0000, 5'd5, 32'h6363_6363, 1);
    // Inverse SubBytes, MixColumns fwd/inv on a constant column
    full_op(1'b1, 1'b0, 32'h6363_6363, 5'd6, 32'h0000_0000, 0);
    full_op(1'b0, 1'b1, 32'h0101_0101, 5'd7, 32'h0101_0101, 0);
    full_op(1'b0, 1'b0, 32'h0101_0101, 5'd8, 32'h0101_0101, 2);

    // Writeback stall, then back-to-back release
    issue(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd9);
    fu_done(32'h6363_6363);
    req_valid = 1'b1;
    req_sub   = 1'b0;
    req_enc   = 1'b1;
    req_rs1   = 32'hA5A5_A5A5;
    req_rs2   = 32'h5A5A_5A5A;
    req_rd    = 5'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      wb_check(5'd9, 32'h6363_6363);
      chk("stall_rdy", {31'd0, req_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    #1;
    chk("b2b_rdy", {31'd0, req_ready}, 32'd1);
    tick();
    wb_ready  = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("b2b_exec", {30'd0, fu_valid, wb_valid}, 32'd2);
    chk("b2b_rs1", fu_rs1, 32'hA5A5_A5A5);
    chk("b2b_rs2", fu_rs2, 32'h5A5A_5A5A);
    fu_done(32'h1234_5678);
    wb_check(5'd10, 32'h1234_5678);
    wb_take();

    // Flush in EXEC; op runs to fu_ready, result dropped
    issue(1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid", {31'd0, fu_valid}, 32'd1);
    chk("fl_rs1", fu_rs1, 32'h1111_1111);
    exec_wait(2, 32'h1111_1111, 32'h2222_2222);
    fu_done(32'hCAFE_F00D);
    chk("fl_idle", {29'd0, fu_valid, wb_valid, busy}, 32'd0);
    chk("fl_nodata", wb_data, 32'h1234_5678);
    // Flush coinciding with fu_ready
    issue(1'b0, 1'b1, 32'h3333_3333, 32'h3333_3333, 5'd12);
    flush = 1'b1;
    fu_done(32'hFEED_FACE);
    flush = 1'b0;
    #1;
    chk("flr_idle", {30'd0, wb_valid, busy}, 32'd0);
    // A fresh op after a flush is not killed
    full_op(1'b0, 1'b0, 32'h0101_0101, 5'd13, 32'h0101_0101, 0);
    // Flush in WB overrides wb_ready and a pending request
    issue(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd14);
    fu_done(32'h6363_6363);
    wb_check(5'd14, 32'h6363_6363);
    flush     = 1'b1;
    wb_ready  = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flwb_rdy", {31'd0, req_ready}, 32'd0);
    tick();
    flush     = 1'b0;
    wb_ready  = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flwb_drop", {29'd0, fu_valid, wb_valid, busy}, 32'd0);

    // Watchdog
    issue(1'b1, 1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 5'd15);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_15", {31'd0, err}, 32'd0);
    tick();
    chk("wd_16", {31'd0, err}, 32'd1);
    exec_wait(3, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
    fu_done(32'h7676_7676);
    wb_check(5'd15, 32'h7676_7676);
    wb_take();
    chk("wd_sticky", {31'd0, err}, 32'd1);
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    #1;
    chk("wd_clr", {31'd0, err}, 32'd0);

    // Reset in EXEC
    issue(1'b0, 1'b1, 32'h4444_4444, 32'h4444_4444, 5'd16);
    g_reset = 1'b1;
    #1;
    chk("rx_rdy", {31'd0, req_ready}, 32'd0);
    tick();
    chk("rx_off", {29'd0, fu_valid, wb_valid, busy}, 32'd0);
    g_reset = 1'b0;
    #1;
    chk("rx_rel", {31'd0, req_ready}, 32'd1);
    // Reset in WB
    issue(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd17);
    fu_done(32'h6363_6363);
    wb_check(5'd17, 32'h6363_6363);
    g_reset = 1'b1;
    tick();
    chk("rw_off", {29'd0, fu_valid, wb_valid, busy}, 32'd0);
    chk("rw_data", wb_data, 32'd0);
    g_reset = 1'b0;
    #1;
    chk("rw_rel", {31'd0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
